dca_matrix_lsu_rdata_unpacker: RTL

Load-side data path of the DCA matrix LSU. It accepts a load transaction descriptor, takes AXI read-data beats from the R channel, and packs consecutive beats into full tensor rows. Rows are handed to the tensor-side row interface with a valid/ready handshake. It is the read counterpart of the LSU store path, which serialises tensor rows into AXI W beats. It sits between the AXI read port of the LSU and the tensor row buffer.

---
 rtl/dca_matrix_lsu_rdata_unpacker_if.sv | 32 +++
 rtl/dca_matrix_lsu_rdata_unpacker.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dca_matrix_lsu_rdata_unpacker_if.sv
// rtl/dca_matrix_lsu_rdata_unpacker_if.sv - descriptor, AXI R and tensor row channels of the load unpacker
interface dca_matrix_lsu_rdata_unpacker_if #(
  parameter int BW_AXI_DATA   = 32,
  parameter int BW_TENSOR_ROW = 128,
  parameter int BW_NUM_ROWS   = 8
);
  logic                     txn_valid;
  logic                     txn_ready;
  logic [BW_NUM_ROWS-1:0]   txn_num_rows;
  logic                     rvalid;
  logic                     rready;
  logic [BW_AXI_DATA-1:0]   rdata;
  logic                     rlast;
  logic [1:0]               rresp;
  logic                     row_valid;
  logic                     row_ready;
  logic [BW_TENSOR_ROW-1:0] row_data;
  logic                     row_last;
  logic                     busy;
  logic                     done;
  logic                     error;

  modport slave (
    input  txn_valid, txn_num_rows, rvalid, rdata, rlast, rresp, row_ready,
    output txn_ready, rready, row_valid, row_data, row_last, busy, done, error
  );

  modport master (
    output txn_valid, txn_num_rows, rvalid, rdata, rlast, rresp, row_ready,
    input  txn_ready, rready, row_valid, row_data, row_last, busy, done, error
  );
endinterface

// File: rtl/dca_matrix_lsu_rdata_unpacker.sv
// rtl/dca_matrix_lsu_rdata_unpacker.sv - packs AXI R beats into tensor rows for the matrix LSU load path
module dca_matrix_lsu_rdata_unpacker #(
  parameter int BW_AXI_DATA   = 32,
  parameter int BW_TENSOR_ROW = 128,
  parameter int BW_NUM_ROWS   = 8
) (
  input  logic clk,
  input  logic rstnn,
  input  logic clear,
  dca_matrix_lsu_rdata_unpacker_if.slave bus
);
  localparam int BEATS_PER_ROW = BW_TENSOR_ROW / BW_AXI_DATA;
  localparam int BW_BEAT_CNT   = $clog2(BEATS_PER_ROW) + 1;
  localparam logic [BW_BEAT_CNT-1:0] LAST_BEAT = BW_BEAT_CNT'(BEATS_PER_ROW - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT, FINISH} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [BW_BEAT_CNT-1:0]   beat_cnt;
  logic [BW_NUM_ROWS-1:0]   rows_left;
  logic [BW_TENSOR_ROW-1:0] row_buf;
  logic                     error_q;
  logic                     txn_fire;
  logic                     beat_fire;
  logic                     row_fire;
  logic                     final_beat;
  logic                     last_row;

  // Handshakes are derived from state directly so clear blocks every transfer in its cycle.
  assign txn_fire   = (state == IDLE)    && !clear && bus.txn_valid;
  assign beat_fire  = (state == COLLECT) && !clear && bus.rvalid;
  assign row_fire   = (state == OUTPUT)  && !clear && bus.row_ready;
  assign final_beat = (beat_cnt == LAST_BEAT);
  assign last_row   = (rows_left == BW_NUM_ROWS'(1));

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.txn_ready = 1'b0;
    bus.rready    = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_last  = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        bus.txn_ready = !clear;
        if (txn_fire) begin
          state_nxt = (bus.txn_num_rows == '0) ? FINISH : COLLECT;
        end
      end
      COLLECT: begin
        bus.rready = !clear;
        if (beat_fire && final_beat) begin
          state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        bus.row_valid = !clear;
        bus.row_last  = last_row;
        if (row_fire) begin
          state_nxt = last_row ? FINISH : COLLECT;
        end
      end
      FINISH: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      beat_cnt  <= '0;
      rows_left <= '0;
      row_buf   <= '0;
      error_q   <= 1'b0;
    end else if (clear) begin
      beat_cnt  <= '0;
      rows_left <= '0;
      row_buf   <= '0;
      error_q   <= 1'b0;
    end else begin
      if (txn_fire) begin
        rows_left <= bus.txn_num_rows;
        beat_cnt  <= '0;
        error_q   <= 1'b0;
      end
      if (beat_fire) begin
        for (int k = 0; k < BEATS_PER_ROW; k++) begin
          if (beat_cnt == BW_BEAT_CNT'(k)) begin
            row_buf[k*BW_AXI_DATA +: BW_AXI_DATA] <= bus.rdata;
          end
        end
        beat_cnt <= final_beat ? '0 : beat_cnt + BW_BEAT_CNT'(1);
        // Bad response or rlast misplaced relative to the row boundary: flag it but keep packing.
        if (bus.rresp[1] || (bus.rlast != final_beat)) begin
          error_q <= 1'b1;
        end
      end
      if (row_fire) begin
        rows_left <= rows_left - BW_NUM_ROWS'(1);
      end
    end
  end

  assign bus.row_data = row_buf;
  assign bus.error    = error_q;
endmodule
